// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter and its round-robin picker.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int CNT_W  = 8;
    localparam int STAT_W = 16;

    function automatic int owner_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: scans from last+1 (mod N), wraps, and ends at last.
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        int cand;
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int off = 1; off <= N; off++) begin
            // Explicit wrap instead of a modulo so non-power-of-two N stays correct.
            cand = int'(last) + off;
            if (cand >= N) cand = cand - N;
            if (!found && req[IDX_W'(cand)]) begin
                found = 1'b1;
                idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-aware round-robin arbiter for a shared async-FIFO write port.
// Optional per-requester beat counters are enabled with FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int MAX_BURST    = 16,
    parameter int IDLE_TIMEOUT = 8,
    localparam int OWN_W       = owner_width(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
`ifdef FIFO_WR_ARB_STATS_EN
    input  logic                          stat_clr,
    output logic [NUM_REQ*STAT_W-1:0]     stat_beats,
`endif
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            grant,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    output logic [OWN_W-1:0]              owner,
    output logic                          busy
);

    arb_state_e       state_q, state_d;
    logic [OWN_W-1:0] owner_q, owner_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;

    logic             pick_found;
    logic [OWN_W-1:0] pick_idx;
    logic             accept;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (OWN_W)
    ) u_rr_pick (
        .req   (req),
        .last  (owner_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign accept       = (state_q == BURST) && req[owner_q] && !fifo_full;
    assign fifo_wr_en   = accept;
    assign grant        = NUM_REQ'(accept) << owner_q;
    assign fifo_wr_data = req_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
    assign owner        = owner_q;
    assign busy         = (state_q == BURST);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        idle_cnt_d = idle_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    owner_d    = pick_idx;
                    state_d    = BURST;
                    beat_cnt_d = '0;
                    idle_cnt_d = '0;
                end
            end
            BURST: begin
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    idle_cnt_d = '0;
                    if (req_last[owner_q] || beat_cnt_q == CNT_W'(MAX_BURST - 1)) begin
                        state_d = IDLE;
                    end
                end else if (!req[owner_q]) begin
                    idle_cnt_d = idle_cnt_q + CNT_W'(1);
                    if (idle_cnt_q == CNT_W'(IDLE_TIMEOUT - 1)) begin
                        state_d = IDLE;
                    end
                end
                // Owner presenting data against a full FIFO: both counters hold.
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= OWN_W'(NUM_REQ - 1);
            beat_cnt_q <= '0;
            idle_cnt_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        logic [STAT_W-1:0] cnt_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else if (stat_clr) begin
                cnt_q <= '0;
            end else if (grant[g] && cnt_q != {STAT_W{1'b1}}) begin
                cnt_q <= cnt_q + STAT_W'(1);
            end
        end

        assign stat_beats[g*STAT_W +: STAT_W] = cnt_q;
    end
`endif

endmodule
